// File: rtl/fejkon_pcie_pkg.sv
// Shared definitions for the PCIe memory-access path.
// fejkon_pcie_data and fejkon_pcie_mem_access both import this package so they agree on the request/response bit layout.
package fejkon_pcie_pkg;

  // Avalon-MM response code for a successful access
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Read data returned when a read is aborted by the watchdog
  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_CMD,
    RESP
  } state_e;

  // Request word: [127]=is_write, [99:96]=byteenable, [95:64]=tag, [63:32]=addr, [31:0]=wdata
  typedef struct packed {
    logic        is_write;
    logic [26:0] rsvd;
    logic [3:0]  byteenable;
    logic [31:0] tag;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_access_req_t;

  // Response word: [127]=error, [126:96]=0, [95:64]=tag, [63:32]=addr, [31:0]=rdata
  typedef struct packed {
    logic        error;
    logic [30:0] rsvd;
    logic [31:0] tag;
    logic [31:0] addr;
    logic [31:0] rdata;
  } mem_access_resp_t;

  // Build a response word with the reserved field forced to zero
  function automatic mem_access_resp_t make_resp(input logic        error,
                                                 input logic [31:0] tag,
                                                 input logic [31:0] addr,
                                                 input logic [31:0] rdata);
    mem_access_resp_t r;
    r.error = error;
    r.rsvd  = '0;
    r.tag   = tag;
    r.addr  = addr;
    r.rdata = rdata;
    return r;
  endfunction

endpackage

// File: rtl/fejkon_pcie_mem_access.sv
// Turns one mem_access request at a time into a single Avalon-MM master transaction.
// Reads return a response (a watchdog turns a hung read into an error response). Writes are posted.
module fejkon_pcie_mem_access
  import fejkon_pcie_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [127:0]      mem_access_req_data,
  input  logic              mem_access_req_valid,
  output logic              mem_access_req_ready,
  output logic [127:0]      mem_access_resp_data,
  output logic              mem_access_resp_valid,
  input  logic              mem_access_resp_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic [1:0]        avm_response
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_access_req_t  req_in;
  logic             unused_req_bits;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      tag_q, tag_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  mem_access_resp_t resp_q, resp_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             avm_read_q, avm_read_d;
  logic             avm_write_q, avm_write_d;
  logic             timeout_hit;
  logic             counting;

  assign req_in          = mem_access_req_t'(mem_access_req_data);
  assign unused_req_bits = ^req_in.rsvd;

  assign mem_access_req_ready  = req_ready_q;
  assign mem_access_resp_valid = resp_valid_q;
  assign mem_access_resp_data  = resp_q;
  assign avm_address           = addr_q[ADDR_W-1:0];
  assign avm_read              = avm_read_q;
  assign avm_write             = avm_write_q;
  assign avm_writedata         = wdata_q;
  assign avm_byteenable        = be_q;

  // Next-state logic: sequence the transaction, run the watchdog, and decode the registered outputs from the next state
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    resp_d      = resp_q;
    timeout_hit = (cnt_q == CNT_LAST);
    counting    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_access_req_valid && req_ready_q) begin
          tag_d   = req_in.tag;
          addr_d  = req_in.addr;
          wdata_d = req_in.wdata;
          be_d    = req_in.byteenable;
          state_d = req_in.is_write ? WR_CMD : RD_CMD;
        end
      end
      RD_CMD: begin
        counting = 1'b1;
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            resp_d  = make_resp(avm_response != RESP_OKAY, tag_q, addr_q, avm_readdata);
            state_d = RESP;
          end else begin
            state_d = RD_DATA;
          end
        end else if (timeout_hit) begin
          resp_d  = make_resp(1'b1, tag_q, addr_q, TIMEOUT_RDATA);
          state_d = RESP;
        end
      end
      RD_DATA: begin
        counting = 1'b1;
        if (avm_readdatavalid) begin
          resp_d  = make_resp(avm_response != RESP_OKAY, tag_q, addr_q, avm_readdata);
          state_d = RESP;
        end else if (timeout_hit) begin
          resp_d  = make_resp(1'b1, tag_q, addr_q, TIMEOUT_RDATA);
          state_d = RESP;
        end
      end
      WR_CMD: begin
        counting = 1'b1;
        if (!avm_waitrequest || timeout_hit) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (mem_access_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (counting) begin
      cnt_d = cnt_q + 1'b1;
    end

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    avm_read_d   = (state_d == RD_CMD);
    avm_write_d  = (state_d == WR_CMD);
  end

  // State, request capture and output registers; reset drops any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tag_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_q       <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      avm_read_q   <= 1'b0;
      avm_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_q       <= resp_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      avm_read_q   <= avm_read_d;
      avm_write_q  <= avm_write_d;
    end
  end

endmodule

// File: tb/tb_fejkon_pcie_mem_access.sv
// Self-checking bench for fejkon_pcie_mem_access with a small watchdog (16 cycles).
// Expected responses and cycle counts come from the request fields and the slave behaviour each test chooses.
module tb_fejkon_pcie_mem_access;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] req_data;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] resp_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  avm_address;
  logic         avm_read;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic [3:0]   avm_byteenable;
  logic         avm_waitrequest;
  logic [31:0]  avm_readdata;
  logic         avm_readdatavalid;
  logic [1:0]   avm_response;

  int errors = 0;
  int checks = 0;

  fejkon_pcie_mem_access #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .mem_access_req_data   (req_data),
    .mem_access_req_valid  (req_valid),
    .mem_access_req_ready  (req_ready),
    .mem_access_resp_data  (resp_data),
    .mem_access_resp_valid (resp_valid),
    .mem_access_resp_ready (resp_ready),
    .avm_address           (avm_address),
    .avm_read              (avm_read),
    .avm_write             (avm_write),
    .avm_writedata         (avm_writedata),
    .avm_byteenable        (avm_byteenable),
    .avm_waitrequest       (avm_waitrequest),
    .avm_readdata          (avm_readdata),
    .avm_readdatavalid     (avm_readdatavalid),
    .avm_response          (avm_response)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample and drive 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_req(input logic wr, input logic [3:0] be, input logic [31:0] tag,
                                           input logic [31:0] addr, input logic [31:0] wdata);
    return {wr, 27'd0, be, tag, addr, wdata};
  endfunction

  function automatic logic [127:0] exp_resp(input logic err, input logic [31:0] tag,
                                             input logic [31:0] addr, input logic [31:0] data);
    return {err, 31'd0, tag, addr, data};
  endfunction

  task automatic drive_rdv(input logic [31:0] data, input logic [1:0] rsp);
    avm_readdatavalid = 1'b1;
    avm_readdata      = data;
    avm_response      = rsp;
  endtask

  task automatic clear_rdv();
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    avm_response      = 2'b00;
  endtask

  // One read: wait_n stall cycles, readdatavalid rdv_delay cycles after command acceptance, resp_ready held low for hold cycles
  task automatic run_read(input logic [31:0] addr, input logic [31:0] tag, input logic [3:0] be,
                          input int wait_n, input int rdv_delay, input logic [1:0] rsp,
                          input logic [31:0] rdata, input int hold, input logic queue_next,
                          input logic [127:0] next_req, input string name);
    logic [127:0] exp;
    exp = exp_resp(rsp != 2'b00, tag, addr, rdata);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s idle_ready: got %b want 1", name, req_ready);
    end
    req_data  = mk_req(1'b0, be, tag, addr, 32'h0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i <= wait_n; i++) begin
      checks++;
      if (avm_read !== 1'b1 || avm_write !== 1'b0 || avm_address !== addr || avm_byteenable !== be || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s rd_cmd[%0d]: read=%b write=%b addr=%h be=%h ready=%b want read=1 write=0 addr=%h be=%h ready=0",
                 name, i, avm_read, avm_write, avm_address, avm_byteenable, req_ready, addr, be);
      end
      avm_waitrequest = (i < wait_n);
      if (i == wait_n && rdv_delay == 0) drive_rdv(rdata, rsp);
      step();
      avm_waitrequest = 1'b0;
      clear_rdv();
    end
    for (int j = 1; j <= rdv_delay; j++) begin
      checks++;
      if (avm_read !== 1'b0 || resp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s rd_data[%0d]: read=%b resp_valid=%b want 0 0", name, j, avm_read, resp_valid);
      end
      if (j == rdv_delay) drive_rdv(rdata, rsp);
      step();
      clear_rdv();
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== exp) begin
      errors++;
      $display("[TB] FAIL %s resp: valid=%b data=%h want valid=1 data=%h", name, resp_valid, resp_data, exp);
    end
    if (queue_next) begin
      req_data  = next_req;
      req_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s hold[%0d]: valid=%b data=%h ready=%b want 1 %h 0", name, h, resp_valid, resp_data, req_ready, exp);
      end
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || avm_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s handshake: resp_valid=%b req_ready=%b read=%b want 0 1 0", name, resp_valid, req_ready, avm_read);
    end
  endtask

  // One posted write with wait_n stall cycles; the command must hold steady and no response may appear
  task automatic run_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                           input int wait_n, input string name);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s idle_ready: got %b want 1", name, req_ready);
    end
    req_data  = mk_req(1'b1, be, 32'h0, addr, wdata);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i <= wait_n; i++) begin
      checks++;
      if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_writedata !== wdata || avm_byteenable !== be ||
          avm_address !== addr || resp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s wr_cmd[%0d]: write=%b read=%b data=%h be=%h addr=%h rv=%b want 1 0 %h %h %h 0",
                 name, i, avm_write, avm_read, avm_writedata, avm_byteenable, avm_address, resp_valid, wdata, be, addr);
      end
      avm_waitrequest = (i < wait_n);
      step();
      avm_waitrequest = 1'b0;
    end
    checks++;
    if (avm_write !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s wr_done: write=%b ready=%b resp_valid=%b want 0 1 0", name, avm_write, req_ready, resp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 128'h0 || avm_read !== 1'b0 || avm_write !== 1'b0 ||
        avm_address !== 32'h0 || avm_writedata !== 32'h0 || avm_byteenable !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ready=%b rv=%b rd=%h read=%b write=%b addr=%h wd=%h be=%h want all 0",
               req_ready, resp_valid, resp_data, avm_read, avm_write, avm_address, avm_writedata, avm_byteenable);
    end
    reset = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_read_zero_wait();
    run_read(32'h100, 32'hA5, 4'hF, 0, 1, 2'b00, 32'hDEADBEEF, 0, 1'b0, 128'h0, "read_zero_wait");
    run_read(32'h203, 32'h7, 4'h0, 0, 0, 2'b00, 32'h0BADF00D, 0, 1'b0, 128'h0, "read_same_cycle_rdv");
  endtask

  task automatic test_write_wait();
    run_write(32'h4000, 4'h3, 32'h12345678, 3, "write_wait3");
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (resp_valid !== 1'b0 || avm_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_no_resp: resp_valid=%b write=%b want 0 0", resp_valid, avm_write);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [127:0] exp;
    // Read stuck in the data phase
    exp = exp_resp(1'b1, 32'h55, 32'h800, 32'hFFFFFFFF);
    req_data  = mk_req(1'b0, 4'hF, 32'h55, 32'h800, 32'h0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != TO || resp_data !== exp) begin
      errors++;
      $display("[TB] FAIL timeout_rd_data: cycles=%0d data=%h want cycles=%0d data=%h", n, resp_data, TO, exp);
    end
    drive_rdv(32'h11111111, 2'b00);
    step();
    clear_rdv();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== exp) begin
      errors++;
      $display("[TB] FAIL timeout_late_rdv: valid=%b data=%h want 1 %h", resp_valid, resp_data, exp);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    drive_rdv(32'h22222222, 2'b00);
    step();
    clear_rdv();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_idle_rdv: resp_valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
    // Read stuck in the command phase
    exp = exp_resp(1'b1, 32'h66, 32'h804, 32'hFFFFFFFF);
    req_data  = mk_req(1'b0, 4'h1, 32'h66, 32'h804, 32'h0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    avm_waitrequest = 1'b1;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    avm_waitrequest = 1'b0;
    checks++;
    if (n != TO || resp_data !== exp || avm_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_rd_cmd: cycles=%0d data=%h read=%b want cycles=%0d data=%h read=0", n, resp_data, avm_read, TO, exp);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    // Write stuck in the command phase
    req_data  = mk_req(1'b1, 4'hF, 32'h0, 32'h900, 32'hA5A5A5A5);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    avm_waitrequest = 1'b1;
    n = 0;
    while (avm_write === 1'b1 && n < 40) begin
      step();
      n++;
    end
    avm_waitrequest = 1'b0;
    checks++;
    if (n != TO || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_wr: cycles=%0d ready=%b resp_valid=%b want cycles=%0d ready=1 resp_valid=0", n, req_ready, resp_valid, TO);
    end
  endtask

  task automatic test_backpressure();
    run_read(32'h1000, 32'h33, 4'hF, 1, 2, 2'b00, 32'hFEEDFACE, 10, 1'b1,
             mk_req(1'b1, 4'hC, 32'h0, 32'h2000, 32'hC0FFEE00), "backpressure");
    step();
    req_valid = 1'b0;
    checks++;
    if (avm_write !== 1'b1 || avm_address !== 32'h2000 || avm_writedata !== 32'hC0FFEE00 || avm_byteenable !== 4'hC) begin
      errors++;
      $display("[TB] FAIL queued_write: write=%b addr=%h data=%h be=%h want 1 00002000 c0ffee00 c",
               avm_write, avm_address, avm_writedata, avm_byteenable);
    end
    step();
    checks++;
    if (avm_write !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL queued_write_done: write=%b ready=%b want 0 1", avm_write, req_ready);
    end
  endtask

  task automatic test_slave_error();
    run_read(32'h3000, 32'h99, 4'hF, 2, 1, 2'b10, 32'hCAFEF00D, 1, 1'b0, 128'h0, "slave_error");
  endtask

  task automatic test_async_reset();
    req_data  = mk_req(1'b0, 4'hF, 32'h44, 32'h500, 32'h0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 128'h0 || avm_read !== 1'b0 || avm_write !== 1'b0 ||
        avm_address !== 32'h0 || avm_writedata !== 32'h0 || avm_byteenable !== 4'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_outputs: ready=%b rv=%b read=%b write=%b addr=%h be=%h want all 0",
               req_ready, resp_valid, avm_read, avm_write, avm_address, avm_byteenable);
    end
    drive_rdv(32'h77777777, 2'b00);
    step();
    clear_rdv();
    reset = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_release: ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
    end
    run_read(32'h504, 32'h45, 4'hF, 0, 1, 2'b00, 32'h600DCAFE, 0, 1'b0, 128'h0, "after_reset_read");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      logic [31:0] t;
      logic [31:0] d;
      logic [3:0]  be;
      logic [1:0]  rsp;
      a   = $urandom;
      t   = $urandom;
      d   = $urandom;
      be  = 4'($urandom_range(15, 0));
      rsp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      if ($urandom_range(1, 0) == 1)
        run_write(a, be, d, int'($urandom_range(3, 0)), "random_write");
      else
        run_read(a, t, be, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), rsp, d,
                 int'($urandom_range(2, 0)), 1'b0, 128'h0, "random_read");
    end
  endtask

  initial begin
    reset             = 1'b1;
    req_data          = 128'h0;
    req_valid         = 1'b0;
    resp_ready        = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = 32'h0;
    avm_readdatavalid = 1'b0;
    avm_response      = 2'b00;
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_backpressure();
    test_slave_error();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
